// File: rtl/prng_chip.sv
// Byte-wide PRNG tile: 8-bit and 16-bit Galois LFSRs, seeded on the first request after reset.
// Each request advances the selected engine STEPS times and registers the low byte with a valid flag.
module prng_chip #(
  parameter int          STEPS  = 8,
  parameter logic [7:0]  POLY8  = 8'hB8,
  parameter logic [15:0] POLY16 = 16'hB400,
  parameter logic [7:0]  ZSEED  = 8'h01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] io_in,
  output logic [8:0] io_out
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t          state, state_nxt;
  logic            en_q, seeded, sel_q, valid;
  logic [CW-1:0]   cnt;
  logic [7:0]      lfsr8, lfsr8_nxt, rand_num, seed_eff;
  logic [15:0]     lfsr16, lfsr16_nxt;

  logic [7:0] seed;
  logic       sel, en, req;

  assign seed     = io_in[9:2];
  assign sel      = io_in[1];
  assign en       = io_in[0];
  assign req      = en & ~en_q;
  assign seed_eff = (seed == 8'h00) ? ZSEED : seed;

  assign lfsr8_nxt  = lfsr8[0]  ? ((lfsr8 >> 1) ^ POLY8)   : (lfsr8 >> 1);
  assign lfsr16_nxt = lfsr16[0] ? ((lfsr16 >> 1) ^ POLY16) : (lfsr16 >> 1);

  assign io_out = {valid, rand_num};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (req) state_nxt = GEN;
      GEN:        if (cnt == LAST) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      en_q     <= 1'b0;
      seeded   <= 1'b0;
      sel_q    <= 1'b0;
      cnt      <= '0;
      lfsr8    <= '0;
      lfsr16   <= '0;
      rand_num <= '0;
      valid    <= 1'b0;
    end else begin
      state <= state_nxt;
      en_q  <= en;
      case (state)
        IDLE, DONE: begin
          if (req) begin
            sel_q <= sel;
            cnt   <= '0;
            valid <= 1'b0;
            // Only the very first request loads the seed; later ones keep streaming.
            if (!seeded) begin
              lfsr8  <= seed_eff;
              lfsr16 <= {seed_eff, ~seed};
              seeded <= 1'b1;
            end
          end
        end
        GEN: begin
          cnt <= cnt + CW'(1);
          if (sel_q) lfsr16 <= lfsr16_nxt;
          else       lfsr8  <= lfsr8_nxt;
          if (cnt == LAST) begin
            rand_num <= sel_q ? lfsr16_nxt[7:0] : lfsr8_nxt;
            valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_chip.sv
// Randomized bench for prng_chip: requests feed a reference model whose expected bytes and
// arrival cycles go into a scoreboard; a monitor pops on every rising valid.
module tb_prng_chip;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] io_in;
  logic [8:0] io_out;

  always #5 clk = ~clk;

  prng_chip dut (
    .clock  (clk),
    .reset  (rst_n),
    .io_in  (io_in),
    .io_out (io_out)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] val;
    int         at;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  int  m8, m16;
  bit  mseeded = 1'b0;
  int  busy_k  = -100;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A request sampled at edge k is accepted unless the engine is still busy with an
  // earlier request; the result appears at edge k+8.
  function automatic void model_req(input int seed, input bit sel, input int k);
    int eff;
    if (k <= busy_k + 8) return;
    busy_k = k;
    if (!mseeded) begin
      eff     = (seed == 0) ? 1 : seed;
      m8      = eff;
      m16     = eff * 256 + (255 - seed);
      mseeded = 1'b1;
    end
    for (int s = 0; s < 8; s++) begin
      if (sel) m16 = (m16 % 2) ? ((m16 / 2) ^ 'hB400) : (m16 / 2);
      else     m8  = (m8 % 2)  ? ((m8 / 2)  ^ 'hB8)   : (m8 / 2);
    end
    sb.push_back('{val: 8'(sel ? (m16 % 256) : m8), at: k + 8});
  endfunction

  function automatic void model_reset();
    mseeded = 1'b0;
    busy_k  = -100;
    sb.delete();
  endfunction

  // Raise en for 'hold' cycles; k is the edge that samples the request.
  task automatic issue(input logic [7:0] seed, input bit sel, input int hold, output int k);
    @(negedge clk);
    k     = cyc + 1;
    io_in = {seed, sel, 1'b1};
    model_req(seed, sel, k);
    repeat (hold) @(negedge clk);
    io_in[0] = 1'b0;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: checks each new result against the scoreboard and that DONE holds its byte.
  bit         pv = 1'b0;
  logic [7:0] last = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (io_out[8] && !pv) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got 0x%0h expected no result (cycle %0d)", io_out[7:0], cyc);
      end else begin
        e = sb.pop_front();
        chk("sb_value", io_out[7:0], e.val);
        chk("sb_latency", cyc, e.at);
      end
    end else if (io_out[8] && pv) begin
      chk("done_hold", io_out[7:0], last);
    end
    pv   = io_out[8];
    last = io_out[7:0];
  end

  initial begin
    int k, k2, t;
    rst_n = 1'b0;
    io_in = 10'($urandom);

    // Reset holds outputs low regardless of io_in
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("reset_out", io_out, 0);
      io_in = 10'($urandom);
    end

    // en already high on the first cycle after release counts as a request
    @(negedge clk);
    rst_n = 1'b1;
    k     = cyc + 1;
    io_in = {8'hCC, 1'b0, 1'b1};
    model_req(8'hCC, 1'b0, k);
    repeat (3) @(negedge clk);
    io_in[0] = 1'b0;
    wait_to(k + 7);
    chk("cc_valid_low", io_out[8], 0);
    wait_to(k + 8);
    chk("cc_result", io_out, {1'b1, 8'hB6});
    repeat (4) @(negedge clk);
    chk("cc_no_second_req", io_out, {1'b1, 8'hB6});

    // Repeated sel=0 requests with random seeds (ignored once seeded) and timing
    for (int r = 0; r < 50; r++) begin
      issue(8'($urandom), 1'b0, $urandom_range(1, 5), k);
      repeat ($urandom_range(8, 20)) @(negedge clk);
    end

    // sel=1 requests interleaved with sel=0; lfsr8 keeps its state across sel=1 runs
    for (int r = 0; r < 12; r++) begin
      issue(8'($urandom), 1'($urandom), $urandom_range(1, 4), k);
      repeat ($urandom_range(8, 16)) @(negedge clk);
    end

    // Request during GEN is ignored, and sel changing mid-GEN has no effect
    issue(8'($urandom), 1'b0, 2, k);
    io_in[1] = 1'b1;
    issue(8'($urandom), 1'b1, 2, k2);
    wait_to(k + 9);
    chk("gen_req_ignored", sb.size(), 0);
    repeat (10) @(negedge clk);

    // Reset mid-GEN clears output and seeding; next request reloads seed (zero -> 0x01)
    issue(8'($urandom), 1'b1, 2, k);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midgen_reset", io_out, 0);
    rst_n = 1'b1;
    io_in = 10'h000;
    repeat (3) @(negedge clk);
    issue(8'h00, 1'b0, 2, k);
    wait_to(k + 8);
    chk("zero_seed", io_out, {1'b1, 8'h64});
    repeat (10) @(negedge clk);

    // Fresh 16-bit seeding after another reset
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 10; r++) begin
      issue(8'($urandom), (r % 3) != 0, $urandom_range(1, 4), k);
      repeat ($urandom_range(8, 14)) @(negedge clk);
    end

    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
